// File: rtl/kem_rej_sampler_pkg.sv
// rtl/kem_rej_sampler_pkg.sv - shared types and constants for the ML-KEM rejection sampler
package kem_rej_sampler_pkg;

    localparam int W_IN   = 256;
    localparam int LEN_C  = 12;
    localparam int Q      = 3329;
    localparam int N_COEF = 256;
    localparam int BUF_W  = W_IN + LEN_C - 1;
    localparam int CNT_W  = 9;

    typedef logic [LEN_C-1:0] coef_t;
    typedef logic [1:0]       rej_state_t;

    localparam rej_state_t S_IDLE  = 2'd0;
    localparam rej_state_t S_RUN   = 2'd1;
    localparam rej_state_t S_DRAIN = 2'd2;

    function automatic logic cand_ok(input coef_t cand);
        return cand < coef_t'(Q);
    endfunction

endpackage

// File: rtl/kem_bitbuf.sv
// rtl/kem_bitbuf.sv - LSB-first append/shift bit buffer feeding the candidate slicer
module kem_bitbuf
    import kem_rej_sampler_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             load_i,
    input  logic [W_IN-1:0]  load_data_i,
    input  logic             take_i,
    output coef_t            head_o,
    output logic [CNT_W-1:0] cnt_o
);

    logic [BUF_W-1:0] buf_q;
    logic [CNT_W-1:0] cnt_q;

    // A load only happens with fewer than LEN_C bits held, so the new word
    // always fits above the residue without overflowing the buffer.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            buf_q <= '0;
            cnt_q <= '0;
        end else if (load_i) begin
            buf_q <= buf_q | (BUF_W'(load_data_i) << cnt_q);
            cnt_q <= cnt_q + CNT_W'(W_IN);
        end else if (take_i) begin
            buf_q <= buf_q >> LEN_C;
            cnt_q <= cnt_q - CNT_W'(LEN_C);
        end
    end

    assign head_o = buf_q[LEN_C-1:0];
    assign cnt_o  = cnt_q;

endmodule

// File: rtl/kem_rej_sampler.sv
// rtl/kem_rej_sampler.sv - uniform rejection sampler streaming 256 coefficients < Q per polynomial
module kem_rej_sampler
    import kem_rej_sampler_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [W_IN-1:0] in_data_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    output logic [LEN_C-1:0] coef_o,
    output logic [7:0]      coef_idx_o,
    output logic            coef_valid_o,
    input  logic            coef_ready_i,
    output logic            coef_last_o,
    output logic            busy_o,
    output logic            done_o
);

    rej_state_t       state_q;
    logic [7:0]       acc_cnt_q;
    coef_t            coef_q;
    logic [7:0]       idx_q;
    logic             valid_q;
    logic             done_q;

    coef_t            head;
    logic [CNT_W-1:0] buf_cnt;
    logic             load;
    logic             take;
    logic             out_hs;

    assign in_ready_o = (state_q == S_RUN) && (buf_cnt < CNT_W'(LEN_C));
    assign load       = in_ready_o && in_valid_i && !start_i;
    assign out_hs     = valid_q && coef_ready_i;
    assign take       = (state_q == S_RUN) && (buf_cnt >= CNT_W'(LEN_C)) &&
                        (!valid_q || coef_ready_i) && !start_i;

    kem_bitbuf u_bitbuf (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clear_i     (start_i),
        .load_i      (load),
        .load_data_i (in_data_i),
        .take_i      (take),
        .head_o      (head),
        .cnt_o       (buf_cnt)
    );

    // acc_cnt_q wraps to 0 on the 256th accept; the state alone marks completion.
    always_ff @(posedge clk_i) begin
        if (rst_i || start_i) begin
            state_q   <= rst_i ? S_IDLE : S_RUN;
            acc_cnt_q <= '0;
            coef_q    <= '0;
            idx_q     <= '0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_RUN: begin
                    if (take && cand_ok(head)) begin
                        coef_q    <= head;
                        idx_q     <= acc_cnt_q;
                        valid_q   <= 1'b1;
                        acc_cnt_q <= acc_cnt_q + 8'd1;
                        if (acc_cnt_q == 8'(N_COEF - 1)) begin
                            state_q <= S_DRAIN;
                        end
                    end else if (out_hs) begin
                        valid_q <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    if (out_hs) begin
                        valid_q <= 1'b0;
                        state_q <= S_IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign coef_o       = coef_q;
    assign coef_idx_o   = idx_q;
    assign coef_valid_o = valid_q;
    assign coef_last_o  = valid_q && (idx_q == 8'(N_COEF - 1));
    assign busy_o       = (state_q != S_IDLE);
    assign done_o       = done_q;

endmodule

// File: tb/tb_kem_rej_sampler.sv
// tb/tb_kem_rej_sampler.sv - self-checking bench for kem_rej_sampler against a bit-stream model
module tb_kem_rej_sampler;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         start_i;
    logic [255:0] in_data_i;
    logic         in_valid_i;
    logic         in_ready_o;
    logic [11:0]  coef_o;
    logic [7:0]   coef_idx_o;
    logic         coef_valid_o;
    logic         coef_ready_i;
    logic         coef_last_o;
    logic         busy_o;
    logic         done_o;

    kem_rej_sampler dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .in_data_i    (in_data_i),
        .in_valid_i   (in_valid_i),
        .in_ready_o   (in_ready_o),
        .coef_o       (coef_o),
        .coef_idx_o   (coef_idx_o),
        .coef_valid_o (coef_valid_o),
        .coef_ready_i (coef_ready_i),
        .coef_last_o  (coef_last_o),
        .busy_o       (busy_o),
        .done_o       (done_o)
    );

    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;

    logic [255:0] src_q[$];
    logic [255:0] feed_q[$];
    logic [11:0]  exp_coef[$];
    int           exp_words;

    logic [11:0]  got_coef[$];
    logic [7:0]   got_idx[$];
    logic         got_last[$];
    int           in_hs_cyc[$];
    int           words_used, done_cnt, done_cyc, last_hs_cyc;
    int           busy_low, stab_viol, valid_seen;

    function automatic logic [255:0] rand_word();
        logic [255:0] w;
        for (int k = 0; k < 8; k++) w[k*32 +: 32] = $urandom;
        return w;
    endfunction

    // Treat the words as one long bit stream, cut 12-bit chunks, keep those < 3329.
    function automatic void model();
        bit         bits[$];
        logic [11:0] cand;
        exp_coef  = {};
        exp_words = 0;
        for (int k = 0; k < src_q.size() && exp_coef.size() < 256; k++) begin
            exp_words++;
            for (int b = 0; b < 256; b++) bits.push_back(src_q[k][b]);
            while (bits.size() >= 12 && exp_coef.size() < 256) begin
                for (int j = 0; j < 12; j++) cand[j] = bits.pop_front();
                if (cand < 12'd3329) exp_coef.push_back(cand);
            end
        end
    endfunction

    task automatic run(input bit do_start, input int max_cyc, input int stop_idx,
                       input int bp_start, input int bp_len, input bit rnd);
        logic        prev_hold = 1'b0;
        logic [11:0] prev_coef = '0;
        logic [7:0]  prev_idx  = '0;
        got_coef = {}; got_idx = {}; got_last = {}; in_hs_cyc = {};
        words_used = 0; done_cnt = 0; done_cyc = -1; last_hs_cyc = -1;
        busy_low = 0; stab_viol = 0; valid_seen = 0;
        for (int c = 0; c < max_cyc; c++) begin
            @(negedge clk_i);
            if (done_o) begin
                done_cnt++;
                done_cyc = c;
                break;
            end
            if (c > 0 && !busy_o) busy_low++;
            if (c > 0 && coef_valid_o) valid_seen++;
            if (prev_hold && (!coef_valid_o || coef_o !== prev_coef || coef_idx_o !== prev_idx))
                stab_viol++;
            start_i      = do_start && (c == 0);
            coef_ready_i = !(c >= bp_start && c < bp_start + bp_len) &&
                           (!rnd || $urandom_range(3) != 0);
            in_valid_i   = !start_i && feed_q.size() > 0 && (!rnd || $urandom_range(2) != 0);
            in_data_i    = (feed_q.size() > 0) ? feed_q[0] : '0;
            prev_hold    = coef_valid_o && !coef_ready_i;
            prev_coef    = coef_o;
            prev_idx     = coef_idx_o;
            if (!start_i && in_valid_i && in_ready_o) begin
                void'(feed_q.pop_front());
                words_used++;
                in_hs_cyc.push_back(c);
            end
            if (!start_i && coef_valid_o && coef_ready_i) begin
                got_coef.push_back(coef_o);
                got_idx.push_back(coef_idx_o);
                got_last.push_back(coef_last_o);
                if (coef_idx_o == 8'd255) last_hs_cyc = c;
                if (int'(coef_idx_o) == stop_idx) break;
            end
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1; start_i = 1'b0; in_valid_i = 1'b1; coef_ready_i = 1'b1; in_data_i = '0;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        n_tests++;
        if ({in_ready_o, coef_o, coef_idx_o, coef_valid_o, coef_last_o, busy_o, done_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got=%h required=0",
                     {in_ready_o, coef_o, coef_idx_o, coef_valid_o, coef_last_o, busy_o, done_o});
        end
        in_valid_i = 1'b0;
    endtask

    task automatic test_all_zero();
        int errs = 0;
        src_q = {};
        repeat (14) src_q.push_back('0);
        model();
        feed_q = src_q;
        run(1'b1, 3000, -1, -1, 0, 1'b0);
        for (int i = 0; i < got_coef.size(); i++)
            if (got_coef[i] !== 12'd0 || got_idx[i] !== 8'(i) || got_last[i] !== (i == 255)) errs++;
        n_tests++;
        if (errs != 0 || got_coef.size() != 256) begin
            n_fail++;
            $display("FAIL zero_stream errs=%0d count=%0d required 256 zero coefs", errs, got_coef.size());
        end
        n_tests++;
        if (words_used != exp_words) begin
            n_fail++;
            $display("FAIL zero_words got=%0d required=%0d", words_used, exp_words);
        end
        n_tests++;
        if (done_cnt != 1 || done_cyc != last_hs_cyc + 1) begin
            n_fail++;
            $display("FAIL zero_done done_cnt=%0d done_cyc=%0d required cycle %0d",
                     done_cnt, done_cyc, last_hs_cyc + 1);
        end
        n_tests++;
        if (busy_low != 0) begin
            n_fail++;
            $display("FAIL zero_busy low_cycles=%0d required=0", busy_low);
        end
        @(negedge clk_i);
        n_tests++;
        if (done_o !== 1'b0 || busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_after_done done=%b busy=%b required 0 0", done_o, busy_o);
        end
    endtask

    task automatic test_all_ones();
        int exp_cyc[$];
        int t = 1, r = 0, errs = 0;
        feed_q = {};
        repeat (14) feed_q.push_back('1);
        while (t < 280) begin
            exp_cyc.push_back(t);
            t += (r + 256) / 12 + 1;
            r  = (r + 256) % 12;
        end
        run(1'b1, 280, -1, -1, 0, 1'b0);
        for (int i = 0; i < exp_cyc.size() && i < in_hs_cyc.size(); i++)
            if (in_hs_cyc[i] != exp_cyc[i]) errs++;
        n_tests++;
        if (valid_seen != 0 || got_coef.size() != 0) begin
            n_fail++;
            $display("FAIL ones_no_coef valid_cycles=%0d required=0", valid_seen);
        end
        n_tests++;
        if (errs != 0 || in_hs_cyc.size() != exp_cyc.size()) begin
            n_fail++;
            $display("FAIL ones_load_spacing errs=%0d loads=%0d required=%0d", errs, in_hs_cyc.size(), exp_cyc.size());
        end
        n_tests++;
        if (busy_low != 0) begin
            n_fail++;
            $display("FAIL ones_busy low_cycles=%0d required=0", busy_low);
        end
    endtask

    task automatic test_boundary();
        logic [255:0] w;
        int errs = 0;
        w = rand_word();
        w[11:0] = 12'd3328; w[23:12] = 12'd3329; w[35:24] = 12'd7;
        src_q = {w};
        repeat (16) src_q.push_back(rand_word());
        model();
        feed_q = src_q;
        run(1'b1, 3000, -1, -1, 0, 1'b0);
        n_tests++;
        if (got_coef.size() < 2 || got_coef[0] !== 12'd3328 || got_idx[0] !== 8'd0 ||
            got_coef[1] !== 12'd7 || got_idx[1] !== 8'd1) begin
            n_fail++;
            $display("FAIL boundary_q got %0d@%0d %0d@%0d required 3328@0 7@1",
                     got_coef.size() > 0 ? got_coef[0] : 0, got_coef.size() > 0 ? got_idx[0] : 0,
                     got_coef.size() > 1 ? got_coef[1] : 0, got_coef.size() > 1 ? got_idx[1] : 0);
        end
        for (int i = 0; i < got_coef.size() && i < 256; i++)
            if (got_coef[i] !== exp_coef[i] || got_idx[i] !== 8'(i)) errs++;
        n_tests++;
        if (errs != 0 || got_coef.size() != 256 || words_used != exp_words) begin
            n_fail++;
            $display("FAIL boundary_stream errs=%0d count=%0d words=%0d required 0/256/%0d",
                     errs, got_coef.size(), words_used, exp_words);
        end
    endtask

    task automatic test_residue();
        logic [255:0] w0, w1;
        w0 = '0; w1 = '0;
        w0[255:252] = 4'hA; w1[7:0] = 8'h5B;
        src_q = {w0, w1};
        repeat (12) src_q.push_back('0);
        model();
        feed_q = src_q;
        run(1'b1, 3000, -1, -1, 0, 1'b0);
        n_tests++;
        if (got_coef.size() < 22 || got_coef[21] !== 12'h5BA || got_idx[21] !== 8'd21 ||
            got_coef[20] !== 12'd0 || got_coef[22] !== 12'd0) begin
            n_fail++;
            $display("FAIL residue_carry got=%h idx=%0d required 5ba idx 21",
                     got_coef.size() > 21 ? got_coef[21] : 12'h0, got_coef.size() > 21 ? got_idx[21] : 0);
        end
        n_tests++;
        if (got_coef.size() != 256 || exp_coef[21] !== 12'h5BA) begin
            n_fail++;
            $display("FAIL residue_count got=%0d required=256", got_coef.size());
        end
    endtask

    task automatic test_backpressure();
        int errs = 0;
        src_q = {};
        repeat (18) src_q.push_back(rand_word());
        model();
        feed_q = src_q;
        run(1'b1, 3000, -1, 60, 10, 1'b0);
        for (int i = 0; i < got_coef.size() && i < 256; i++)
            if (got_coef[i] !== exp_coef[i] || got_idx[i] !== 8'(i) || got_last[i] !== (i == 255)) errs++;
        n_tests++;
        if (stab_viol != 0) begin
            n_fail++;
            $display("FAIL bp_stable violations=%0d required=0", stab_viol);
        end
        n_tests++;
        if (errs != 0 || got_coef.size() != 256 || done_cnt != 1) begin
            n_fail++;
            $display("FAIL bp_stream errs=%0d count=%0d done=%0d required 0/256/1", errs, got_coef.size(), done_cnt);
        end
    endtask

    task automatic test_restart();
        int errs = 0;
        src_q = {};
        repeat (18) src_q.push_back(rand_word());
        model();
        feed_q = src_q;
        run(1'b1, 3000, 100, -1, 0, 1'b1);
        for (int i = 0; i < got_coef.size() && i < 101; i++)
            if (got_coef[i] !== exp_coef[i] || got_idx[i] !== 8'(i)) errs++;
        n_tests++;
        if (errs != 0 || got_coef.size() != 101) begin
            n_fail++;
            $display("FAIL restart_prefix errs=%0d count=%0d required 0/101", errs, got_coef.size());
        end
        src_q = {};
        repeat (18) src_q.push_back(rand_word());
        model();
        feed_q = src_q;
        errs = 0;
        run(1'b1, 3000, -1, -1, 0, 1'b1);
        for (int i = 0; i < got_coef.size() && i < 256; i++)
            if (got_coef[i] !== exp_coef[i] || got_idx[i] !== 8'(i)) errs++;
        n_tests++;
        if (errs != 0 || got_coef.size() != 256 || words_used != exp_words || done_cnt != 1) begin
            n_fail++;
            $display("FAIL restart_fresh errs=%0d count=%0d words=%0d/%0d done=%0d",
                     errs, got_coef.size(), words_used, exp_words, done_cnt);
        end
    endtask

    task automatic test_reset_midrun();
        int errs = 0, bad = 0;
        src_q = {};
        repeat (18) src_q.push_back(rand_word());
        feed_q = src_q;
        run(1'b1, 3000, 50, -1, 0, 1'b0);
        @(negedge clk_i);
        rst_i = 1'b1; in_valid_i = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0; in_valid_i = 1'b1; coef_ready_i = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk_i);
            if ({in_ready_o, coef_o, coef_idx_o, coef_valid_o, coef_last_o, busy_o, done_o} !== '0) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL rst_midrun_idle bad_cycles=%0d required=0", bad);
        end
        in_valid_i = 1'b0;
        src_q = {};
        repeat (18) src_q.push_back(rand_word());
        model();
        feed_q = src_q;
        run(1'b1, 3000, -1, -1, 0, 1'b0);
        for (int i = 0; i < got_coef.size() && i < 256; i++)
            if (got_coef[i] !== exp_coef[i] || got_idx[i] !== 8'(i)) errs++;
        n_tests++;
        if (errs != 0 || got_coef.size() != 256 || words_used != exp_words) begin
            n_fail++;
            $display("FAIL rst_midrun_fresh errs=%0d count=%0d words=%0d required 0/256/%0d",
                     errs, got_coef.size(), words_used, exp_words);
        end
    endtask

    task automatic test_random();
        for (int p = 0; p < 3; p++) begin
            int errs = 0;
            src_q = {};
            repeat (20) src_q.push_back(rand_word());
            model();
            feed_q = src_q;
            run(1'b1, 3000, -1, -1, 0, 1'b1);
            for (int i = 0; i < got_coef.size() && i < 256; i++)
                if (got_coef[i] !== exp_coef[i] || got_idx[i] !== 8'(i) || got_last[i] !== (i == 255)) errs++;
            n_tests++;
            if (errs != 0 || got_coef.size() != 256 || words_used != exp_words ||
                done_cnt != 1 || stab_viol != 0) begin
                n_fail++;
                $display("FAIL random_poly%0d errs=%0d count=%0d words=%0d/%0d done=%0d stab=%0d",
                         p, errs, got_coef.size(), words_used, exp_words, done_cnt, stab_viol);
            end
        end
    endtask

    initial begin
        test_reset();
        test_all_zero();
        test_all_ones();
        test_boundary();
        test_residue();
        test_backpressure();
        test_restart();
        test_reset_midrun();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
